collision_checker: RTL and testbench

//  Parametrised, sequential successor to the spawn-time game-over check. It tests an
//   N x N float-block mask at an anchor position against the settled board and the board edges.
//  The board is read one row per cycle through a synchronous row-read port.

---
 rtl/collision_checker_if.sv | 37 +++
 rtl/collision_checker.sv | 158 +++++++++++++++
 tb/tb_collision_checker.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/collision_checker_if.sv
`default_nettype none
// ============================================================================
// Interface : collision_checker_if
// Request/result handshake and board row-read port of the collision checker.
// Rev       : 1.0
// ============================================================================
interface collision_checker_if #(
  parameter int BOARD_W = 10,
  parameter int PIECE_N = 4,
  parameter int X_W     = 4,
  parameter int Y_W     = 5
);
  logic                           start;
  logic                           mode;
  logic [X_W-1:0]                 pos_x;
  logic [Y_W-1:0]                 pos_y;
  logic [0:PIECE_N*PIECE_N-1]     float;
  logic                           clr_game_over;
  logic                           row_rd;
  logic [Y_W-1:0]                 row_addr;
  logic [BOARD_W-1:0]             row_data;
  logic                           busy;
  logic                           done;
  logic                           collide;
  logic                           game_over;

  modport master (
    output start, mode, pos_x, pos_y, float, clr_game_over, row_data,
    input  row_rd, row_addr, busy, done, collide, game_over
  );

  modport slave (
    input  start, mode, pos_x, pos_y, float, clr_game_over, row_data,
    output row_rd, row_addr, busy, done, collide, game_over
  );
endinterface
`default_nettype wire

// File: rtl/collision_checker.sv
`default_nettype none
// ============================================================================
// Module : collision_checker
// Sequential mask-vs-board collision check, one board row read per cycle.
// Rev    : 1.0
// ============================================================================
module collision_checker #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int PIECE_N = 4,
  parameter int X_W     = 4,
  parameter int Y_W     = 5
) (
  input wire                 clk,
  input wire                 rst_n,
  collision_checker_if.slave cc
);

  localparam int c_nn    = PIECE_N * PIECE_N;
  localparam int c_r_w   = (PIECE_N > 1) ? $clog2(PIECE_N) : 1;
  localparam int c_k_w   = $clog2(PIECE_N + 1);
  localparam int c_pad_w = 2 ** (X_W + 1);
  localparam logic [Y_W:0]     c_board_h = (Y_W + 1)'(BOARD_H);
  localparam logic [c_k_w-1:0] c_k_last  = c_k_w'(PIECE_N - 1);
  localparam logic [c_k_w-1:0] c_k_flush = c_k_w'(PIECE_N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FLUSH = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t             state_q;
  logic [c_k_w-1:0]   k_q;
  logic               mode_q;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [0:c_nn-1]    mask_q;
  logic               acc_q;
  logic               collide_q;
  logic               game_over_q;
  logic               game_over_d;
  logic               busy_q;
  logic               done_q;
  logic               row_rd_q;
  logic [Y_W-1:0]     row_addr_q;

  logic [PIECE_N-1:0] w_rows [PIECE_N];
  logic [PIECE_N-1:0] w_row_any;
  logic [c_r_w-1:0]   w_cmp_row;
  logic [c_r_w-1:0]   w_nxt_row;
  logic [Y_W:0]       w_cmp_y;
  logic [Y_W:0]       w_nxt_y;
  logic               w_nxt_rd;
  logic               w_in_rd0;
  logic [c_pad_w-1:0] w_pad;
  logic [PIECE_N-1:0] w_pad_sel;
  logic               w_hit;
  logic               w_go_set;

  for (genvar r = 0; r < PIECE_N; r++) begin : g_rows
    for (genvar c = 0; c < PIECE_N; c++) begin : g_cols
      assign w_rows[r][c] = mask_q[r*PIECE_N + c];
    end
    assign w_row_any[r] = |w_rows[r];
  end

  // Row k-1 is compared while row k is read; FLUSH parks k at N so this yields N-1.
  assign w_cmp_row = c_r_w'(k_q - 1'b1);
  assign w_nxt_row = c_r_w'(k_q + 1'b1);
  assign w_cmp_y   = (Y_W + 1)'(y_q) + (Y_W + 1)'(w_cmp_row);
  assign w_nxt_y   = (Y_W + 1)'(y_q) + (Y_W + 1)'(w_nxt_row);
  assign w_nxt_rd  = w_row_any[w_nxt_row] && (w_nxt_y < c_board_h);
  assign w_in_rd0  = (|cc.float[0:PIECE_N-1]) && ((Y_W + 1)'(cc.pos_y) < c_board_h);

  // Columns past the right edge and rows below the floor read as solid.
  assign w_pad = (w_cmp_y < c_board_h) ? {{(c_pad_w - BOARD_W){1'b1}}, cc.row_data} : '1;

  for (genvar c = 0; c < PIECE_N; c++) begin : g_sel
    assign w_pad_sel[c] = w_pad[(X_W + 1)'(x_q) + (X_W + 1)'(c)];
  end

  assign w_hit       = |(w_rows[w_cmp_row] & w_pad_sel);
  assign w_go_set    = (state_q == S_FIN) && mode_q && collide_q;
  assign game_over_d = w_go_set ? 1'b1 : (cc.clr_game_over ? 1'b0 : game_over_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      mode_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      mask_q      <= '0;
      acc_q       <= 1'b0;
      collide_q   <= 1'b0;
      game_over_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      row_rd_q    <= 1'b0;
      row_addr_q  <= '0;
    end else begin
      done_q      <= 1'b0;
      game_over_q <= game_over_d;
      case (state_q)
        S_IDLE: begin
          if (cc.start) begin
            state_q    <= S_SCAN;
            mode_q     <= cc.mode;
            x_q        <= cc.pos_x;
            y_q        <= cc.pos_y;
            mask_q     <= cc.float;
            k_q        <= '0;
            acc_q      <= 1'b0;
            collide_q  <= 1'b0;
            busy_q     <= 1'b1;
            row_rd_q   <= w_in_rd0;
            row_addr_q <= cc.pos_y;
          end
        end
        S_SCAN: begin
          if (k_q != '0) begin
            acc_q <= acc_q | w_hit;
          end
          if (k_q == c_k_last) begin
            state_q  <= S_FLUSH;
            k_q      <= c_k_flush;
            row_rd_q <= 1'b0;
          end else begin
            k_q        <= k_q + 1'b1;
            row_rd_q   <= w_nxt_rd;
            row_addr_q <= w_nxt_y[Y_W-1:0];
          end
        end
        S_FLUSH: begin
          state_q   <= S_FIN;
          collide_q <= acc_q | w_hit;
          done_q    <= 1'b1;
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cc.row_rd    = row_rd_q;
  assign cc.row_addr  = row_addr_q;
  assign cc.busy      = busy_q;
  assign cc.done      = done_q;
  assign cc.collide   = collide_q;
  assign cc.game_over = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_collision_checker.sv
`default_nettype none
// ============================================================================
// Module : tb_collision_checker
// Directed self-checking bench for collision_checker.
// Rev    : 1.0
// ============================================================================
module tb_collision_checker;

  logic       clk;
  logic       rst_n;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt;
  logic [9:0] board [32];

  collision_checker_if #(.BOARD_W(10), .PIECE_N(4), .X_W(4), .Y_W(5)) bus ();

  collision_checker #(
    .BOARD_W(10), .BOARD_H(20), .PIECE_N(4), .X_W(4), .Y_W(5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cc    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous board RAM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (!rst_n) bus.row_data <= '0;
    else if (bus.row_rd) bus.row_data <= board[bus.row_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_chk(input string tag, input logic m, input logic [3:0] x,
                         input logic [4:0] y, input logic [15:0] f, input logic clr_done,
                         input logic exp_col, input logic [31:0] exp_rd, input logic exp_go);
    logic [31:0] rd;
    rd = '0;
    bus.start = 1'b1;
    bus.mode  = m;
    bus.pos_x = x;
    bus.pos_y = y;
    bus.float = f;
    tick;
    bus.start = 1'b0;
    bus.mode  = ~m;
    bus.pos_x = ~x;
    bus.pos_y = ~y;
    bus.float = ~f;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (bus.row_rd) rd[bus.row_addr] = 1'b1;
      chk({tag, ".done"}, 32'(bus.done), 32'(cyc == 6));
      chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
      chk({tag, ".collide"}, 32'(bus.collide), (cyc == 6) ? 32'(exp_col) : 32'd0);
      if (cyc == 6) bus.clr_game_over = clr_done;
      tick;
    end
    bus.clr_game_over = 1'b0;
    chk({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
    chk({tag, ".done_end"}, 32'(bus.done), 32'd0);
    chk({tag, ".collide_hold"}, 32'(bus.collide), 32'(exp_col));
    chk({tag, ".game_over"}, 32'(bus.game_over), 32'(exp_go));
    chk({tag, ".rows_read"}, rd, exp_rd);
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.start         = 1'b0;
    bus.mode          = 1'b0;
    bus.pos_x         = '0;
    bus.pos_y         = '0;
    bus.float         = '0;
    bus.clr_game_over = 1'b0;
    for (int i = 0; i < 32; i++) board[i] = '0;

    tick;
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.collide", 32'(bus.collide), 32'd0);
    chk("rst.game_over", 32'(bus.game_over), 32'd0);
    chk("rst.row_rd", 32'(bus.row_rd), 32'd0);
    chk("rst.row_addr", 32'(bus.row_addr), 32'd0);
    rst_n = 1'b1;
    tick;

    run_chk("T1", 1'b1, 4'd3, 5'd0, 16'h0660, 1'b0, 1'b0, 32'h0000_0006, 1'b0);

    board[1] = 10'b0000010000;
    run_chk("T2", 1'b1, 4'd3, 5'd0, 16'h0660, 1'b0, 1'b1, 32'h0000_0006, 1'b1);
    run_chk("T2b", 1'b1, 4'd3, 5'd5, 16'h0660, 1'b0, 1'b0, 32'h0000_00C0, 1'b1);
    bus.clr_game_over = 1'b1;
    tick;
    bus.clr_game_over = 1'b0;
    chk("T2.clr", 32'(bus.game_over), 32'd0);

    run_chk("T3", 1'b0, 4'd7, 5'd5, 16'hF000, 1'b0, 1'b1, 32'h0000_0020, 1'b0);
    run_chk("T4", 1'b0, 4'd3, 5'd18, 16'h0660, 1'b0, 1'b1, 32'h0008_0000, 1'b0);

    board[10] = 10'b1000000000;
    run_chk("EDGE_HIT", 1'b0, 4'd6, 5'd10, 16'hF000, 1'b0, 1'b1, 32'h0000_0400, 1'b0);
    run_chk("EDGE_OK", 1'b0, 4'd6, 5'd11, 16'hF000, 1'b0, 1'b0, 32'h0000_0800, 1'b0);
    run_chk("EMPTY", 1'b1, 4'd3, 5'd0, 16'h0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0);

    run_chk("T6", 1'b1, 4'd3, 5'd0, 16'h0660, 1'b1, 1'b1, 32'h0000_0006, 1'b1);
    run_chk("T6b", 1'b1, 4'd3, 5'd5, 16'h0660, 1'b1, 1'b0, 32'h0000_00C0, 1'b0);

    // Starts during an active check (including its done cycle) must be dropped.
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    bus.pos_x = 4'd7;
    bus.pos_y = 5'd5;
    bus.float = 16'hF000;
    tick;
    bus.start = 1'b0;
    done_cnt  = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (bus.done) done_cnt++;
      if (cyc == 6) chk("T5a.collide", 32'(bus.collide), 32'd1);
      if (cyc >= 7) chk("T5a.busy_idle", 32'(bus.busy), 32'd0);
      bus.start = (cyc == 2) || (cyc == 6);
      if (cyc == 2) begin
        bus.mode  = 1'b1;
        bus.pos_x = 4'd3;
        bus.pos_y = 5'd0;
        bus.float = 16'h0660;
      end
      tick;
    end
    bus.start = 1'b0;
    chk("T5a.done_count", 32'(done_cnt), 32'd1);
    chk("T5a.game_over", 32'(bus.game_over), 32'd0);

    // Reset mid-scan aborts with no done pulse.
    bus.start = 1'b1;
    bus.mode  = 1'b1;
    bus.pos_x = 4'd3;
    bus.pos_y = 5'd0;
    bus.float = 16'h0660;
    tick;
    bus.start = 1'b0;
    tick;
    tick;
    chk("T5b.row_rd_pre", 32'(bus.row_rd), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("T5b.busy", 32'(bus.busy), 32'd0);
    chk("T5b.done", 32'(bus.done), 32'd0);
    chk("T5b.collide", 32'(bus.collide), 32'd0);
    chk("T5b.row_rd", 32'(bus.row_rd), 32'd0);
    chk("T5b.row_addr", 32'(bus.row_addr), 32'd0);
    chk("T5b.game_over", 32'(bus.game_over), 32'd0);
    tick;
    tick;
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (bus.done) done_cnt++;
      tick;
    end
    chk("T5b.no_done", 32'(done_cnt), 32'd0);
    chk("T5b.busy_after", 32'(bus.busy), 32'd0);
    chk("T5b.game_over_after", 32'(bus.game_over), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
